// File: rtl/hls_deadlock_monitor_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hls_deadlock_monitor_param_if : stall-source and report bundle for the   |
// | deadlock monitor.                                     Revision: 1.0      |
// +--------------------------------------------------------------------------+
interface hls_deadlock_monitor_param_if #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int CNT_W    = 16
);
  localparam int SRC_W  = NUM_AXIS + NUM_INST;
  localparam int IDX_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  // Zero instances still needs a legal vector; the monitor ignores it then.
  localparam int INST_W = (NUM_INST > 0) ? NUM_INST : 1;

  logic                enable;
  logic                clear;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [INST_W-1:0]   inst_idle_sigs;
  logic [INST_W-1:0]   inst_block_sigs;
  logic                block;
  logic [SRC_W-1:0]    block_src;
  logic [IDX_W-1:0]    first_idx;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, block_src, first_idx, stall_cycles
  );

  modport slave (
    input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, block_src, first_idx, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hls_deadlock_monitor_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hls_deadlock_monitor_param : threshold-filtered deadlock detector with   |
// | source snapshot, first offender and stall length. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module hls_deadlock_monitor_param #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int THRESH   = 1,
  parameter int CNT_W    = 16,
  parameter int STICKY   = 0
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  hls_deadlock_monitor_param_if.slave mon
);
  localparam int SRC_W = NUM_AXIS + NUM_INST;
  localparam int IDX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SRC_W-1:0] r_src, w_src_nxt;
  logic [IDX_W-1:0] r_first, w_first_nxt;
  logic [CNT_W-1:0] r_stall, w_stall_nxt, w_stall_inc;
  logic [SRC_W-1:0] w_src_vec;
  logic [IDX_W-1:0] w_first;
  logic             w_raw;

  // An instance only counts as stalled when it is blocked and not idle.
  generate
    if (NUM_INST > 0) begin : g_inst
      assign w_src_vec = {mon.inst_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs};
    end else begin : g_no_inst
      logic unused_inst;
      assign w_src_vec   = mon.axis_block_sigs;
      assign unused_inst = ^{mon.inst_block_sigs, mon.inst_idle_sigs};
    end
  endgenerate

  assign w_raw       = mon.enable & (|w_src_vec);
  assign w_stall_inc = (r_stall == {CNT_W{1'b1}}) ? r_stall : r_stall + 1'b1;

  always_comb begin
    w_first = '0;
    for (int i = SRC_W - 1; i >= 0; i--) begin
      if (w_src_vec[i]) w_first = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_src_nxt   = r_src;
    w_first_nxt = r_first;
    w_stall_nxt = w_raw ? w_stall_inc : '0;
    case (r_state)
      S_IDLE: begin
        if (w_raw) begin
          if (THRESH == 1) begin
            w_state_nxt = S_BLOCKED;
            w_src_nxt   = w_src_vec;
            w_first_nxt = w_first;
          end else begin
            w_state_nxt = S_SUSPECT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (!w_raw) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == THR_M1) begin
          w_state_nxt = S_BLOCKED;
          w_cnt_nxt   = '0;
          w_src_nxt   = w_src_vec;
          w_first_nxt = w_first;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BLOCKED: begin
        if (w_raw) begin
          w_src_nxt = r_src | w_src_vec;
        end else if (STICKY != 0) begin
          // Sticky report freezes the stall length until software clears it.
          w_stall_nxt = r_stall;
        end else begin
          w_state_nxt = S_IDLE;
          w_src_nxt   = '0;
          w_first_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_src_nxt   = '0;
        w_first_nxt = '0;
        w_stall_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_first <= '0;
      r_stall <= '0;
    end else if (mon.clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_first <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_src   <= w_src_nxt;
      r_first <= w_first_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  assign mon.block        = (r_state == S_BLOCKED);
  assign mon.block_src    = r_src;
  assign mon.first_idx    = r_first;
  assign mon.stall_cycles = r_stall;
endmodule
`default_nettype wire
